rv32i_single_cycle_datapath: RTL and testbench
==============================================

Name: rv32i_single_cycle_datapath

Overview:
- Single-cycle RV32I integer datapath: PC, 32x32 register file, ALU, immediate generation, branch/jump unit and a word-addressed data memory.
- Instructions are not stored internally. The external instruction memory/bench drives `load_ins` combinationally from `pc`.
- Debug ports expose the register file and data memory to the cpu I/O interface and test program.

Parameters:
- DMEM_DEPTH, 256, number of 32-bit data memory words; must be a power of 2.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 = reset.
- pc  output  32  current program counter, i.e. the address of the instruction being executed.
- load_ins  input  32  instruction word at address `pc`, executed this cycle.
- load_data_rgf  input  5  register index for debug read.
- data_register_file  output  32  combinational contents of register[`load_data_rgf`]; index 0 always reads 0.
- inst_out  output  32  copy of the instruction currently executing (`load_ins`).
- dmem  output  32  combinational data-memory word at the current effective address: (rs1 + imm)[log2(DMEM_DEPTH)+1:2]. Valid for loads/stores; a don't-care value for other instructions but still deterministic.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc = RESET_PC.
  - All registers x1..x31 = 0.
  - All data memory words = 0.
  - No writes occur while reset is low.
  - Reset released mid-program resumes at RESET_PC with cleared state.
- Execution: every rising clk edge with reset=1 commits exactly one instruction. CPI = 1; there is no pipeline or stall.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - LW, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- Immediates: I/S/B/U/J formats are sign-extended per the RISC-V spec. B and J offsets are in bytes with bit 0 = 0.
- ALU arithmetic is 32-bit modulo 2^32; overflow is ignored.
- Shift amount = low 5 bits of the operand.
- SLT/BLT/BGE compare signed; SLTU/BLTU/BGEU compare unsigned.
- Next PC:
  - Default pc+4.
  - Taken branch: pc+immB.
  - JAL: pc+immJ.
  - JALR: (rs1+immI) & ~1.
  - All wrap modulo 2^32.
- Writeback at the clock edge, to rd if rd != 0:
  - ALU result for ALU ops.
  - Memory word for LW.
  - pc+4 for JAL/JALR.
  - immU for LUI.
  - pc+immU for AUIPC.
- x0 is never written and always reads 0.
- Register reads are combinational from the pre-edge state. Same-cycle rs = rd uses the old value; the new value is visible next cycle.
- Data memory:
  - Word addressed; effective address bits [1:0] are ignored (no misalignment trap).
  - Index = address[log2(DMEM_DEPTH)+1:2]; addresses beyond the depth wrap.
  - SW writes rs2 at the edge. LW reads combinationally.
  - Byte/halfword loads and stores are not supported.
- Unsupported or illegal opcodes (including FENCE, ECALL, all-zero word) execute as NOP: no register or memory write, pc+4.
- `inst_out` and `data_register_file` are combinational and change with their inputs or state within the same cycle.

Test Plan:
- Reset: reset=0 for 2 cycles, then release -> pc=0; `data_register_file`=0 for every `load_data_rgf` 0..31; `dmem`=0.
- ALU sequence:
  - Program: ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x1,x2; SLT x5,x2,x1; SLTU x6,x2,x1; SRAI x7,x2,1.
  - Expect x3=2, x4=8, x5=1, x6=0, x7=0xFFFFFFFE.
  - pc steps 0,4,...,0x18.
- Memory:
  - Program: ADDI x1,x0,0x55; SW x1,8(x0); LW x2,8(x0).
  - Expect x2=0x55 and `dmem`=0x55 during the LW cycle.
  - SW to address 8+4*DMEM_DEPTH aliases to word 2.
- Branch/jump:
  - BEQ x0,x0,+8 at pc=0 -> next pc=8.
  - BNE x0,x0,+8 -> pc+4.
  - JAL x1,+16 at pc=8 -> pc=24, x1=12.
  - JALR x0,x1,1 with x1=12 -> pc=12.
- x0/NOP: ADDI x0,x0,7 -> x0 reads 0. Word 0x00000000 -> no state change, pc+4. LUI x9,0x12345 -> x9=0x12345000.
- Async reset mid-run: assert reset=0 between clock edges after 3 instructions -> pc=0 and registers cleared immediately, before the next edge.

Source files
------------

// File: rtl/rv32i_single_cycle_datapath.sv
// Single-cycle RV32I integer datapath: PC, register file, ALU, immediates,
// branch/jump resolution and a word-addressed data memory with debug taps.
module rv32i_single_cycle_datapath #(
    parameter int unsigned DMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] load_ins,
    input  logic [4:0]  load_data_rgf,
    output logic [31:0] data_register_file,
    output logic [31:0] inst_out,
    output logic [31:0] dmem
);

    localparam int unsigned AW = $clog2(DMEM_DEPTH);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] regs [32];
    logic [31:0] mem  [DMEM_DEPTH];

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] ea;
    logic [AW-1:0] mem_idx;
    logic [31:0] mem_rdata;
    logic [31:0] pc_plus4;
    logic        unused_ea_bits;

    // Field decode and immediate formats
    assign opcode = load_ins[6:0];
    assign rd     = load_ins[11:7];
    assign f3     = load_ins[14:12];
    assign rs1    = load_ins[19:15];
    assign rs2    = load_ins[24:20];
    assign f7     = load_ins[31:25];

    assign imm_i = {{20{load_ins[31]}}, load_ins[31:20]};
    assign imm_s = {{20{load_ins[31]}}, load_ins[31:25], load_ins[11:7]};
    assign imm_b = {{19{load_ins[31]}}, load_ins[31], load_ins[7],
                    load_ins[30:25], load_ins[11:8], 1'b0};
    assign imm_u = {load_ins[31:12], 12'b0};
    assign imm_j = {{11{load_ins[31]}}, load_ins[31], load_ins[19:12],
                    load_ins[20], load_ins[30:21], 1'b0};

    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    // Effective address doubles as the JALR target (rs1 + immI)
    assign ea        = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign mem_idx   = ea[AW+1:2];
    assign mem_rdata = mem[mem_idx];
    assign unused_ea_bits = ^{ea[31:AW+2], ea[1:0]};

    assign pc_plus4           = pc + 32'd4;
    assign dmem               = mem_rdata;
    assign inst_out           = load_ins;
    assign data_register_file = (load_data_rgf == 5'd0) ? 32'd0 : regs[load_data_rgf];

    logic [31:0] alu_b;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic        alu_ok;
    logic        f7_free;

    // ALU; alu_ok flags funct7 encodings that are legal for the op
    always_comb begin
        alu_b   = (opcode == OP_REG) ? rs2_val : imm_i;
        shamt   = alu_b[4:0];
        f7_free = (opcode == OP_IMM);
        alu_res = 32'd0;
        alu_ok  = f7_free || (f7 == 7'h00);
        case (f3)
            3'b000: begin
                if (opcode == OP_REG && f7 == 7'h20) begin
                    alu_res = rs1_val - alu_b;
                    alu_ok  = 1'b1;
                end else begin
                    alu_res = rs1_val + alu_b;
                end
            end
            3'b001: begin
                alu_res = rs1_val << shamt;
                alu_ok  = (f7 == 7'h00);
            end
            3'b010: alu_res = {31'd0, $signed(rs1_val) < $signed(alu_b)};
            3'b011: alu_res = {31'd0, rs1_val < alu_b};
            3'b100: alu_res = rs1_val ^ alu_b;
            3'b101: begin
                alu_ok = (f7 == 7'h00) || (f7 == 7'h20);
                if (f7[5]) begin
                    alu_res = 32'($signed(rs1_val) >>> shamt);
                end else begin
                    alu_res = rs1_val >> shamt;
                end
            end
            3'b110: alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    logic br_taken;

    always_comb begin
        br_taken = 1'b0;
        case (f3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val <  rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    logic [31:0] next_pc;
    logic [31:0] wb_data;
    logic        reg_we;
    logic        mem_we;

    // Control: anything not recognised falls through as a NOP
    always_comb begin
        next_pc = pc_plus4;
        wb_data = 32'd0;
        reg_we  = 1'b0;
        mem_we  = 1'b0;
        case (opcode)
            OP_LUI: begin
                reg_we  = 1'b1;
                wb_data = imm_u;
            end
            OP_AUIPC: begin
                reg_we  = 1'b1;
                wb_data = pc + imm_u;
            end
            OP_JAL: begin
                reg_we  = 1'b1;
                wb_data = pc_plus4;
                next_pc = pc + imm_j;
            end
            OP_JALR: begin
                if (f3 == 3'b000) begin
                    reg_we  = 1'b1;
                    wb_data = pc_plus4;
                    next_pc = {ea[31:1], 1'b0};
                end
            end
            OP_BRANCH: begin
                if (br_taken) begin
                    next_pc = pc + imm_b;
                end
            end
            OP_LOAD: begin
                if (f3 == 3'b010) begin
                    reg_we  = 1'b1;
                    wb_data = mem_rdata;
                end
            end
            OP_STORE: begin
                mem_we = (f3 == 3'b010);
            end
            OP_IMM, OP_REG: begin
                reg_we  = alu_ok;
                wb_data = alu_res;
            end
            default: begin
                next_pc = pc_plus4;
            end
        endcase
    end

    // PC and register file commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            pc <= next_pc;
            if (reg_we && rd != 5'd0) begin
                regs[rd] <= wb_data;
            end
        end
    end

    // Data memory; cleared by reset like the register file
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DMEM_DEPTH); i++) begin
                mem[i] <= 32'd0;
            end
        end else if (mem_we) begin
            mem[mem_idx] <= rs2_val;
        end
    end

endmodule

// File: tb/tb_rv32i_single_cycle_datapath.sv
// Directed bench for rv32i_single_cycle_datapath; instruction memory is a
// bench-side array read combinationally from pc.
module tb_rv32i_single_cycle_datapath;

    localparam logic [31:0] HALT = 32'h0000_006f;  // JAL x0,0: self-loop

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] load_ins;
    logic [4:0]  load_data_rgf;
    logic [31:0] data_register_file;
    logic [31:0] inst_out;
    logic [31:0] dmem;

    logic [31:0] imem [64];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign load_ins = imem[pc[7:2]];

    rv32i_single_cycle_datapath #(.DMEM_DEPTH(256), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .reset(reset),
        .pc(pc),
        .load_ins(load_ins),
        .load_data_rgf(load_data_rgf),
        .data_register_file(data_register_file),
        .inst_out(inst_out),
        .dmem(dmem)
    );

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input int op);
        return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                          input int f3);
        logic [12:0] im;
        im = 13'(imm);
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [20:0] im;
        im = 21'(imm);
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6f};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
        return {20'(imm20), 5'(rd), 7'(op)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd_reg(input int r, output logic [31:0] v);
        load_data_rgf = 5'(r);
        #1;
        v = data_register_file;
    endtask

    task automatic begin_prog;
        reset = 1'b0;
        for (int i = 0; i < 64; i++) imem[i] = HALT;
        @(posedge clk);
        #1;
    endtask

    task automatic run;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        reset = 1'b0;
        load_data_rgf = 5'd0;
        for (int i = 0; i < 64; i++) imem[i] = HALT;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_pc_held got=%h want=%h", pc, 32'h0);
        end
        run();
        total++;
        if (pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_pc got=%h want=%h", pc, 32'h0);
        end
        for (int r = 0; r < 32; r++) begin
            rd_reg(r, v);
            total++;
            if (v !== 32'h0) begin
                bad++;
                $display("FAIL reset_reg x%0d got=%h want=%h", r, v, 32'h0);
            end
        end
        total++;
        if (dmem !== 32'h0) begin
            bad++;
            $display("FAIL reset_dmem got=%h want=%h", dmem, 32'h0);
        end
    endtask

    task automatic test_alu;
        logic [31:0] v;
        int          ri  [7] = '{1, 2, 3, 4, 5, 6, 7};
        logic [31:0] exp [7] = '{32'd5, 32'hFFFF_FFFD, 32'd2, 32'd8, 32'd1, 32'd0, 32'hFFFF_FFFE};
        begin_prog();
        imem[0] = enc_i(5, 0, 0, 1, 'h13);
        imem[1] = enc_i(-3, 0, 0, 2, 'h13);
        imem[2] = enc_r('h00, 2, 1, 0, 3);
        imem[3] = enc_r('h20, 2, 1, 0, 4);
        imem[4] = enc_r('h00, 1, 2, 2, 5);
        imem[5] = enc_r('h00, 1, 2, 3, 6);
        imem[6] = enc_i('h401, 2, 5, 7, 'h13);
        run();
        total++;
        if (inst_out !== 32'h0050_0093) begin
            bad++;
            $display("FAIL alu_inst_out got=%h want=%h", inst_out, 32'h0050_0093);
        end
        for (int i = 0; i <= 7; i++) begin
            total++;
            if (pc !== 32'(4 * i)) begin
                bad++;
                $display("FAIL alu_pc step%0d got=%h want=%h", i, pc, 32'(4 * i));
            end
            step(1);
        end
        for (int i = 0; i < 7; i++) begin
            rd_reg(ri[i], v);
            total++;
            if (v !== exp[i]) begin
                bad++;
                $display("FAIL alu_x%0d got=%h want=%h", ri[i], v, exp[i]);
            end
        end
    endtask

    task automatic test_logic;
        logic [31:0] v;
        logic [31:0] exp [15] = '{32'hFFFF_FFF0, 32'hFFFF_FF0F, 32'h0000_00F0, 32'h0000_0030,
                                  32'h0FFF_FFFF, 32'd33, 32'h0000_01E0, 32'd1,
                                  32'hFFFF_FFF8, 32'd1, 32'h0000_00F0, 32'hFFFF_FFFF,
                                  32'h0000_00FF, 32'h7FFF_FFF8, 32'd1};
        begin_prog();
        imem[0]  = enc_i(-16, 0, 0, 1, 'h13);
        imem[1]  = enc_i('hFF, 1, 4, 2, 'h13);
        imem[2]  = enc_i('hF0, 0, 6, 3, 'h13);
        imem[3]  = enc_i('h3C, 1, 7, 4, 'h13);
        imem[4]  = enc_i(4, 1, 5, 5, 'h13);
        imem[5]  = enc_i(33, 0, 0, 6, 'h13);
        imem[6]  = enc_r('h00, 6, 3, 1, 7);
        imem[7]  = enc_i(1, 0, 3, 8, 'h13);
        imem[8]  = enc_r('h20, 6, 1, 5, 9);
        imem[9]  = enc_i(-15, 1, 2, 10, 'h13);
        imem[10] = enc_r('h00, 3, 1, 7, 11);
        imem[11] = enc_r('h00, 3, 2, 6, 12);
        imem[12] = enc_r('h00, 2, 1, 4, 13);
        imem[13] = enc_r('h00, 6, 1, 5, 14);
        imem[14] = enc_r('h00, 1, 3, 3, 15);
        run();
        step(15);
        for (int i = 0; i < 15; i++) begin
            rd_reg(i + 1, v);
            total++;
            if (v !== exp[i]) begin
                bad++;
                $display("FAIL logic_x%0d got=%h want=%h", i + 1, v, exp[i]);
            end
        end
    endtask

    task automatic test_memory;
        logic [31:0] v;
        begin_prog();
        imem[0] = enc_i('h55, 0, 0, 1, 'h13);
        imem[1] = enc_s(8, 1, 0);
        imem[2] = enc_i(8, 0, 2, 2, 'h03);
        imem[3] = enc_i('h66, 0, 0, 3, 'h13);
        imem[4] = enc_s(8 + 4 * 256, 3, 0);
        imem[5] = enc_i(8, 0, 2, 4, 'h03);
        run();
        step(2);
        total++;
        if (dmem !== 32'h55) begin
            bad++;
            $display("FAIL mem_dmem_lw got=%h want=%h", dmem, 32'h55);
        end
        step(1);
        rd_reg(2, v);
        total++;
        if (v !== 32'h55) begin
            bad++;
            $display("FAIL mem_lw_x2 got=%h want=%h", v, 32'h55);
        end
        step(2);
        total++;
        if (dmem !== 32'h66) begin
            bad++;
            $display("FAIL mem_alias_dmem got=%h want=%h", dmem, 32'h66);
        end
        step(1);
        rd_reg(4, v);
        total++;
        if (v !== 32'h66) begin
            bad++;
            $display("FAIL mem_alias_x4 got=%h want=%h", v, 32'h66);
        end
    endtask

    task automatic test_branch;
        logic [31:0] v;
        logic [31:0] exp_pc [8] = '{32'd8, 32'd24, 32'd12, 32'd16, 32'd20, 32'd28, 32'd32, 32'd32};
        begin_prog();
        imem[0] = enc_b(8, 0, 0, 0);
        imem[1] = enc_i(1, 0, 0, 5, 'h13);
        imem[2] = enc_j(16, 1);
        imem[3] = enc_b(8, 0, 0, 1);
        imem[4] = enc_i(-1, 0, 0, 2, 'h13);
        imem[5] = enc_b(8, 2, 0, 6);
        imem[6] = enc_i(1, 1, 0, 0, 'h67);
        imem[7] = enc_b(8, 2, 0, 4);
        run();
        for (int i = 0; i < 8; i++) begin
            step(1);
            total++;
            if (pc !== exp_pc[i]) begin
                bad++;
                $display("FAIL branch_pc step%0d got=%h want=%h", i, pc, exp_pc[i]);
            end
        end
        rd_reg(1, v);
        total++;
        if (v !== 32'd12) begin
            bad++;
            $display("FAIL branch_jal_link got=%h want=%h", v, 32'd12);
        end
        rd_reg(5, v);
        total++;
        if (v !== 32'd0) begin
            bad++;
            $display("FAIL branch_skipped_x5 got=%h want=%h", v, 32'd0);
        end
    endtask

    task automatic test_x0_nop;
        logic [31:0] v;
        begin_prog();
        imem[0] = enc_i(7, 0, 0, 0, 'h13);
        imem[1] = 32'h0000_0000;
        imem[2] = enc_u('h12345, 9, 'h37);
        imem[3] = enc_u(1, 10, 'h17);
        imem[4] = 32'h0000_0073;
        run();
        step(1);
        rd_reg(0, v);
        total++;
        if (v !== 32'd0) begin
            bad++;
            $display("FAIL x0_write got=%h want=%h", v, 32'd0);
        end
        total++;
        if (inst_out !== 32'h0) begin
            bad++;
            $display("FAIL nop_inst_out got=%h want=%h", inst_out, 32'h0);
        end
        step(1);
        total++;
        if (pc !== 32'd8) begin
            bad++;
            $display("FAIL nop_pc got=%h want=%h", pc, 32'd8);
        end
        step(3);
        total++;
        if (pc !== 32'd20) begin
            bad++;
            $display("FAIL ecall_pc got=%h want=%h", pc, 32'd20);
        end
        rd_reg(9, v);
        total++;
        if (v !== 32'h1234_5000) begin
            bad++;
            $display("FAIL lui_x9 got=%h want=%h", v, 32'h1234_5000);
        end
        rd_reg(10, v);
        total++;
        if (v !== 32'h0000_100C) begin
            bad++;
            $display("FAIL auipc_x10 got=%h want=%h", v, 32'h0000_100C);
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] v;
        begin_prog();
        imem[0] = enc_i(5, 0, 0, 1, 'h13);
        imem[1] = enc_i(6, 0, 0, 2, 'h13);
        imem[2] = enc_s(4, 1, 0);
        imem[3] = enc_i(7, 0, 0, 3, 'h13);
        run();
        step(3);
        rd_reg(1, v);
        total++;
        if (v !== 32'd5) begin
            bad++;
            $display("FAIL areset_pre_x1 got=%h want=%h", v, 32'd5);
        end
        total++;
        if (dmem !== 32'd5) begin
            bad++;
            $display("FAIL areset_pre_dmem got=%h want=%h", dmem, 32'd5);
        end
        #1;
        reset = 1'b0;
        #1;
        total++;
        if (pc !== 32'd0) begin
            bad++;
            $display("FAIL areset_pc got=%h want=%h", pc, 32'd0);
        end
        rd_reg(1, v);
        total++;
        if (v !== 32'd0) begin
            bad++;
            $display("FAIL areset_x1 got=%h want=%h", v, 32'd0);
        end
        rd_reg(2, v);
        total++;
        if (v !== 32'd0) begin
            bad++;
            $display("FAIL areset_x2 got=%h want=%h", v, 32'd0);
        end
        total++;
        if (dmem !== 32'd0) begin
            bad++;
            $display("FAIL areset_dmem got=%h want=%h", dmem, 32'd0);
        end
        reset = 1'b1;
        step(1);
        total++;
        if (pc !== 32'd4) begin
            bad++;
            $display("FAIL areset_resume_pc got=%h want=%h", pc, 32'd4);
        end
        rd_reg(1, v);
        total++;
        if (v !== 32'd5) begin
            bad++;
            $display("FAIL areset_resume_x1 got=%h want=%h", v, 32'd5);
        end
    endtask

    initial begin
        reset = 1'b0;
        load_data_rgf = 5'd0;
        test_reset();
        test_alu();
        test_logic();
        test_memory();
        test_branch();
        test_x0_nop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
